// File: rtl/vga_mode_sequencer.sv
// vga_mode_sequencer: owns the VGA timing parameters and switches modes at frame boundaries behind a reset/blank window. Define VGA_MODE_SEQ_TIMEOUT_EN to add a WAIT_FRAME timeout.
module vga_mode_sequencer #(
  parameter int HOLD_CYCLES    = 16,
  parameter int SETTLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MODE,
  input  logic        FRAME_END,
  output logic [31:0] VAL,
  output logic [11:0] H_VIS,
  output logic [11:0] V_VIS,
  output logic [7:0]  H_FRONT,
  output logic [7:0]  H_SYNC,
  output logic [7:0]  H_BACK,
  output logic [7:0]  V_FRONT,
  output logic [7:0]  V_SYNC,
  output logic [7:0]  V_BACK,
  output logic        SYNC_INV,
  output logic        TIMING_RST,
  output logic        BLANK,
  output logic        ACTIVE_MODE,
  output logic        BUSY
);
  localparam logic [2:0] HOLD       = 3'd0;
  localparam logic [2:0] LOAD       = 3'd1;
  localparam logic [2:0] SETTLE     = 3'd2;
  localparam logic [2:0] RUN        = 3'd3;
  localparam logic [2:0] WAIT_FRAME = 3'd4;
`ifdef VGA_MODE_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_MAX = TO_EN ? TIMEOUT_CYCLES : 1;
  localparam int MAX_A  = HOLD_CYCLES > SETTLE_FRAMES ? HOLD_CYCLES : SETTLE_FRAMES;
  localparam int MAX_C  = MAX_A > TO_MAX ? MAX_A : TO_MAX;
  localparam int CW     = $clog2(MAX_C + 1);
  // Packed as {VAL, H_VIS, H_FRONT, H_SYNC, H_BACK, V_VIS, V_FRONT, V_SYNC, V_BACK}
  localparam logic [103:0] P0 = {32'd2, 12'd640, 8'd16, 8'd96, 8'd48, 12'd480, 8'd10, 8'd2, 8'd33};
  localparam logic [103:0] P1 = {32'd1, 12'd800, 8'd56, 8'd120, 8'd64, 12'd600, 8'd37, 8'd6, 8'd23};

  logic          m1_q, ms_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          target_q, target_d;
  logic          act_q;
  logic [103:0]  prm_q;
  logic          trst_q, blank_q, busy_q;
  logic          inc, to_w;

`ifdef VGA_MODE_SEQ_TIMEOUT_EN
  assign to_w = cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
  assign to_w = 1'b0;
`endif

  assign {VAL, H_VIS, H_FRONT, H_SYNC, H_BACK, V_VIS, V_FRONT, V_SYNC, V_BACK} = prm_q;
  assign SYNC_INV    = act_q;
  assign ACTIVE_MODE = act_q;
  assign TIMING_RST  = trst_q;
  assign BLANK       = blank_q;
  assign BUSY        = busy_q;

  // Next state, target capture and the shared per-state counter (cleared on every state change)
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      HOLD:       state_d = cnt_q == CW'(HOLD_CYCLES - 1) ? LOAD : HOLD;
      LOAD:       state_d = SETTLE;
      SETTLE:     state_d = FRAME_END && cnt_q == CW'(SETTLE_FRAMES - 1) ? RUN : SETTLE;
      RUN:        state_d = ms_q != act_q ? WAIT_FRAME : RUN;
      WAIT_FRAME: begin
        state_d  = ms_q == act_q ? RUN : (FRAME_END || to_w) ? HOLD : WAIT_FRAME;
        target_d = ms_q != act_q && (FRAME_END || to_w) ? ms_q : target_q;
      end
      default:    state_d = HOLD;
    endcase
    inc   = state_q == HOLD || (state_q == SETTLE && FRAME_END) || (state_q == WAIT_FRAME && TO_EN);
    cnt_d = state_d != state_q ? '0 : cnt_q + CW'(inc);
  end

  // MODE synchronizer, FSM registers and registered outputs decoded from the next state
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      m1_q     <= 1'b0;
      ms_q     <= 1'b0;
      state_q  <= HOLD;
      cnt_q    <= '0;
      target_q <= 1'b0;
      act_q    <= 1'b0;
      prm_q    <= P0;
      trst_q   <= 1'b1;
      blank_q  <= 1'b1;
      busy_q   <= 1'b1;
    end else begin
      m1_q     <= MODE;
      ms_q     <= m1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      act_q    <= state_d == LOAD ? target_q : act_q;
      prm_q    <= state_d == LOAD ? (target_q ? P1 : P0) : prm_q;
      trst_q   <= state_d == HOLD || state_d == LOAD;
      blank_q  <= state_d == HOLD || state_d == LOAD || state_d == SETTLE;
      busy_q   <= state_d != RUN;
    end
endmodule

// File: tb/tb_vga_mode_sequencer.sv
// tb_vga_mode_sequencer: randomized and directed checks of vga_mode_sequencer against a countdown-based behavioural model.
module tb_vga_mode_sequencer;
  localparam int HOLD   = 16;
  localparam int SETTLE = 2;
  localparam int TO     = 50;
`ifdef VGA_MODE_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        CLK, RST, MODE, FRAME_END;
  logic [31:0] VAL;
  logic [11:0] H_VIS, V_VIS;
  logic [7:0]  H_FRONT, H_SYNC, H_BACK, V_FRONT, V_SYNC, V_BACK;
  logic        SYNC_INV, TIMING_RST, BLANK, ACTIVE_MODE, BUSY;

  vga_mode_sequencer #(.HOLD_CYCLES(HOLD), .SETTLE_FRAMES(SETTLE), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .FRAME_END(FRAME_END),
    .VAL(VAL), .H_VIS(H_VIS), .V_VIS(V_VIS),
    .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .SYNC_INV(SYNC_INV), .TIMING_RST(TIMING_RST), .BLANK(BLANK),
    .ACTIVE_MODE(ACTIVE_MODE), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum int {M_HOLD, M_LOAD, M_SETTLE, M_RUN, M_WAIT} ph_t;
  ph_t  ph;
  int   left, frames, waited;
  logic tgt, act, s1, s2, mode_r;
  int   errors = 0;
  int   checks = 0;
  int   p [2][9] = '{'{2, 640, 16, 96, 48, 480, 10, 2, 33}, '{1, 800, 56, 120, 64, 600, 37, 6, 23}};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = M_HOLD;
    left = HOLD;
    tgt = 1'b0;
    act = 1'b0;
    s1 = 1'b0;
    s2 = 1'b0;
    frames = 0;
    waited = 0;
  endtask

  task automatic model_step();
    case (ph)
      M_HOLD: begin
        left = left - 1;
        if (left == 0) begin ph = M_LOAD; act = tgt; end
      end
      M_LOAD: begin ph = M_SETTLE; frames = 0; end
      M_SETTLE: if (FRAME_END) begin
        frames = frames + 1;
        if (frames == SETTLE) ph = M_RUN;
      end
      M_RUN: if (s2 != act) begin ph = M_WAIT; waited = 0; end
      M_WAIT: begin
        waited = waited + 1;
        if (s2 == act) ph = M_RUN;
        else if (FRAME_END || (TO_EN && waited == TO)) begin ph = M_HOLD; tgt = s2; left = HOLD; end
      end
      default: ph = M_HOLD;
    endcase
    s2 = s1;
    s1 = MODE;
  endtask

  task automatic cmp_all();
    check("TIMING_RST", TIMING_RST, ph == M_HOLD || ph == M_LOAD);
    check("BLANK", BLANK, ph == M_HOLD || ph == M_LOAD || ph == M_SETTLE);
    check("BUSY", BUSY, ph != M_RUN);
    check("ACTIVE_MODE", ACTIVE_MODE, act);
    check("SYNC_INV", SYNC_INV, act);
    check("VAL", VAL, p[act][0]);
    check("H_VIS", H_VIS, p[act][1]);
    check("H_FRONT", H_FRONT, p[act][2]);
    check("H_SYNC", H_SYNC, p[act][3]);
    check("H_BACK", H_BACK, p[act][4]);
    check("V_VIS", V_VIS, p[act][5]);
    check("V_FRONT", V_FRONT, p[act][6]);
    check("V_SYNC", V_SYNC, p[act][7]);
    check("V_BACK", V_BACK, p[act][8]);
  endtask

  task automatic cycle(input logic m, input logic fe, input logic r);
    @(negedge CLK);
    cmp_all();
    MODE = m;
    FRAME_END = fe;
    RST = r;
    if (r) model_reset();
    @(posedge CLK);
    if (!r) model_step();
  endtask

  task automatic settle();
    int n = 0;
    while (n < 3000 && !(ph == M_RUN && s1 == act && s2 == act && mode_r == act)) begin
      cycle(mode_r, $urandom_range(0, 7) == 0, 1'b0);
      n++;
    end
    check("settle_done", n < 3000, 1'b1);
  endtask

  initial begin
    int   edges;
    logic low, seen, r;
    RST = 1'b0;
    MODE = 1'b0;
    FRAME_END = 1'b0;
    mode_r = 1'b0;
    #1 RST = 1'b1;
    model_reset();
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    edges = 0;
    low = 1'b0;
    for (int i = 0; i < 100 && !low; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      edges++;
      #1 low = !TIMING_RST;
    end
    check("trst_edges", edges, HOLD + 1);
    settle();
    #1 check("startup_hvis", H_VIS, 640);
    check("startup_busy", BUSY, 1'b0);
    mode_r = 1'b1;
    repeat (100) cycle(1'b1, 1'b0, 1'b0);
    #1 check("wait_blank", BLANK, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    #1 check("fe_trst", TIMING_RST, 1'b1);
    check("fe_blank", BLANK, 1'b1);
    settle();
    #1 check("switch_val", VAL, 1);
    seen = 1'b0;
    for (int i = 0; i < 23; i++) begin
      cycle(i < 3 ? !mode_r : mode_r, 1'b0, 1'b0);
      #1 seen = seen | TIMING_RST;
    end
    check("withdraw_trst", seen, 1'b0);
    check("withdraw_active", ACTIVE_MODE, mode_r);
    mode_r = !mode_r;
    repeat (5) cycle(mode_r, 1'b0, 1'b0);
    cycle(mode_r, 1'b1, 1'b0);
    for (int i = 0; i < 100 && ph != M_SETTLE; i++) cycle(mode_r, 1'b0, 1'b0);
    mode_r = !mode_r;
    settle();
    #1 check("toggle_active", ACTIVE_MODE, mode_r);
    if (act) begin
      mode_r = 1'b0;
      settle();
    end
    mode_r = 1'b1;
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    #1 check("midhold_trst", TIMING_RST, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    #1 check("rst_hvis", H_VIS, 640);
    check("rst_active", ACTIVE_MODE, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 1'b1);
    settle();
    #1 check("restart_active", ACTIVE_MODE, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) mode_r = !mode_r;
      r = $urandom_range(0, 1499) == 0;
      cycle(mode_r, $urandom_range(0, 14) == 0, r);
      if (r) repeat (2) cycle(mode_r, 1'b0, 1'b1);
    end
    settle();
    mode_r = !mode_r;
    repeat (3000) cycle(mode_r, 1'b0, 1'b0);
    #1 check("stall_blank", BLANK, TO_EN);
    check("stall_busy", BUSY, 1'b1);
    cycle(mode_r, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
